// File: rtl/lab3_scan_ctrl.sv
// Scan controller: classifies a stream of 5-bit words (or a sweep of all 32 codes)
// through an external combinational classifier and keeps saturating result counters.
module lab3_scan_ctrl #(
    parameter int N_WORDS = 8,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [4:0]    din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [4:0]    cls_x,
    input  logic          cls_res,
    input  logic          cls_state,
    output logic [CW-1:0] cnt_res,
    output logic [CW-1:0] cnt_state,
    output logic [CW-1:0] cnt_none,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0]    LAST_W  = 8'(N_WORDS - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic       mode_q;
    logic [7:0] wcnt;
    logic [4:0] idx;
    logic       take, last;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        din_ready = 1'b0;
        cls_x     = '0;
        take      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (mode_q) begin
                    cls_x = idx;
                    take  = 1'b1;
                    last  = (idx == 5'd31);
                end else begin
                    din_ready = 1'b1;
                    cls_x     = din;
                    take      = din_valid;
                    last      = (wcnt == LAST_W);
                end
                if (take && last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            wcnt      <= '0;
            idx       <= '0;
            cnt_res   <= '0;
            cnt_state <= '0;
            cnt_none  <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                mode_q    <= mode;
                wcnt      <= '0;
                idx       <= '0;
                cnt_res   <= '0;
                cnt_state <= '0;
                cnt_none  <= '0;
                err       <= 1'b0;
            end else if (take) begin
                wcnt <= wcnt + 8'd1;
                idx  <= idx + 5'd1;
                // res wins over state; both together is a classifier fault
                if (cls_res) begin
                    if (cnt_res != CNT_MAX) cnt_res <= cnt_res + CNT_ONE;
                    if (cls_state) err <= 1'b1;
                end else if (cls_state) begin
                    if (cnt_state != CNT_MAX) cnt_state <= cnt_state + CNT_ONE;
                end else begin
                    if (cnt_none != CNT_MAX) cnt_none <= cnt_none + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/lab3_scan_ctrl.md
LAB3_SCAN_CTRL -- requirements
Module: lab3_scan_ctrl

Interface
REQ-001 Parameter N_WORDS, default 8: number of words accepted per stream-mode run (1..255).
REQ-002 Parameter CW, default 8: width of every result counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a run; sampled in IDLE only.
REQ-006 mode  input  1  sampled with start: 0 = stream words from din, 1 = sweep all 32 codes internally.
REQ-007 din  input  5  stream-mode word.
REQ-008 din_valid  input  1  din holds a word.
REQ-009 din_ready  output  1  controller accepts din this cycle.
REQ-010 cls_x  output  5  code driven to the external 5-bit classifier.
REQ-011 cls_res  input  1  classifier "res" flag for cls_x, combinational, same cycle.
REQ-012 cls_state  input  1  classifier "x_state" flag for cls_x, combinational, same cycle.
REQ-013 cnt_res  output  CW  words classified res.
REQ-014 cnt_state  output  CW  words classified state-only.
REQ-015 cnt_none  output  CW  words with neither flag.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse at end of run.
REQ-018 err  output  1  sticky: classifier returned both flags during the current run.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE on last word; DONE->IDLE unconditionally after one cycle.
REQ-020 On the IDLE cycle with start=1, the controller SHALL clear all counters and err, and latch mode; RUN begins next cycle.
REQ-021 start while in RUN or DONE SHALL be ignored.
REQ-022 Stream mode: din_ready=1 throughout RUN; cls_x=din combinationally; a word is accepted in a cycle with din_valid=1 and din_ready=1.
REQ-023 Stream mode: cycles with din_valid=0 SHALL change no counter or word count; RUN->DONE after the N_WORDS-th accepted word.
REQ-024 Sweep mode: din_ready=0; cls_x = internal index, 0 in the first RUN cycle, +1 per cycle; one code classified every cycle; RUN->DONE after code 31 (exactly 32 RUN cycles).
REQ-025 cls_x SHALL be 0 in IDLE and DONE; din_ready SHALL be 0 outside stream-mode RUN.
REQ-026 Per classified word: cls_res=1 -> cnt_res+1; else cls_state=1 -> cnt_state+1; else cnt_none+1.
REQ-027 cls_res=1 and cls_state=1 together SHALL increment cnt_res only and set err.
REQ-028 Counters SHALL saturate at 2^CW-1, never wrap.
REQ-029 done SHALL be high only in DONE; counters and err SHALL hold their values from DONE until the next accepted start.

Reset
REQ-030 With rst_n=0 at a rising edge: state=IDLE, all counters=0, err=0, done=0, busy=0, din_ready=0, cls_x=0, word count and sweep index=0.
REQ-031 Reset SHALL take priority over every other input, including mid-run; no done pulse follows a reset-aborted run.

Verification
REQ-032 Sweep: start=1, mode=1 in cycle 0 with a reference classifier -> busy cycles 1..32, done in cycle 33, cnt_res=17, cnt_state=4, cnt_none=11, err=0.
REQ-033 Stream, N_WORDS=8: din 00000,00110,00011,10000,11110,10111,11111,01100 with valid gaps of 1-3 cycles -> cnt_res=3, cnt_state=3, cnt_none=2; done one cycle after the 8th accept.
REQ-034 Saturation, CW=4, N_WORDS=20: 20 words of 00000 -> cnt_res=15, others 0.
REQ-035 Reset mid-run: rst_n=0 at sweep index 10 -> next cycle IDLE, counters 0, no done; fresh sweep then gives 17/4/11.
REQ-036 start pulsed in RUN -> ignored, counters unaffected; bench classifier forcing both flags on one word -> err=1, cnt_res+1, err held until next start.
